// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the HD44780 4-bit-mode path through a PCF8574 expander.
package lcd_pkg;

    localparam int RS_BIT     = 0;
    localparam int RW_BIT     = 1;
    localparam int EN_BIT     = 2;
    localparam int BL_BIT     = 3;
    localparam int DATA_SHIFT = 4;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int DEF_SHORT_DELAY = 50;
    localparam int DEF_LONG_DELAY  = 2000;
    localparam int MIN_CNT_W       = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY
    } seq_state_t;

    function automatic logic [7:0] port_byte(
        input logic [3:0] nib,
        input logic       en,
        input logic       bl,
        input logic       rs
    );
        logic [7:0] b;
        b         = 8'(nib) << DATA_SHIFT;
        b[RS_BIT] = rs;
        b[RW_BIT] = 1'b0;
        b[EN_BIT] = en;
        b[BL_BIT] = bl;
        return b;
    endfunction

    // 8'h03 decodes as return-home on the controller, so it gets the long wait too.
    function automatic logic is_slow_cmd(
        input logic       rs,
        input logic [7:0] cmd,
        input logic       nib_only
    );
        return !rs && !nib_only &&
               ((cmd == CMD_CLEAR) || (cmd == CMD_HOME) || (cmd == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter that flags the last cycle of a post-byte execution wait.
module lcd_delay_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    // Expiry on a count of one so a load of N spans exactly N enabled cycles.
    assign o_expired = (r_count <= W'(1));

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// Splits one HD44780 byte into EN-strobed PCF8574 port writes, then waits the execution time.
module lcd_nibble_sequencer
    import lcd_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h27,
    parameter int         SHORT_DELAY = DEF_SHORT_DELAY,
    parameter int         LONG_DELAY  = DEF_LONG_DELAY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] byte_in,
    input  logic       nibble_only,
    input  logic       backlight,
    output logic       ready,
    output logic       done,
    output logic       i2c_start,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    input  logic       i2c_busy,
    input  logic       i2c_done
);

    localparam int CNT_W = ($clog2(LONG_DELAY + 1) > MIN_CNT_W) ?
                           $clog2(LONG_DELAY + 1) : MIN_CNT_W;

    seq_state_t r_state, w_state_next;

    logic       r_rs, w_rs_next;
    logic [7:0] r_byte, w_byte_next;
    logic       r_nib_only, w_nib_only_next;
    logic       r_bl, w_bl_next;
    logic       r_long, w_long_next;
    logic [1:0] r_idx, w_idx_next;
    logic [7:0] r_data, w_data_next;
    logic       r_start, w_start_next;
    logic       r_done, w_done_next;

    logic [1:0]       w_last_idx;
    logic [1:0]       w_idx_inc;
    logic [7:0]       w_following_byte;
    logic [CNT_W-1:0] w_delay;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tmr_expired;

    lcd_delay_timer #(
        .W(CNT_W)
    ) u_delay_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_delay),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Write index: bit1 selects low nibble, bit0 selects the EN-low half of the strobe.
    assign w_last_idx       = r_nib_only ? 2'd1 : 2'd3;
    assign w_idx_inc        = r_idx + 2'd1;
    assign w_following_byte = port_byte(w_idx_inc[1] ? r_byte[3:0] : r_byte[7:4],
                                        ~w_idx_inc[0], r_bl, r_rs);
    assign w_delay          = r_long ? CNT_W'(LONG_DELAY) : CNT_W'(SHORT_DELAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rs       <= 1'b0;
            r_byte     <= 8'h00;
            r_nib_only <= 1'b0;
            r_bl       <= 1'b0;
            r_long     <= 1'b0;
            r_idx      <= 2'd0;
            r_data     <= 8'h00;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rs       <= w_rs_next;
            r_byte     <= w_byte_next;
            r_nib_only <= w_nib_only_next;
            r_bl       <= w_bl_next;
            r_long     <= w_long_next;
            r_idx      <= w_idx_next;
            r_data     <= w_data_next;
            r_start    <= w_start_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rs_next       = r_rs;
        w_byte_next     = r_byte;
        w_nib_only_next = r_nib_only;
        w_bl_next       = r_bl;
        w_long_next     = r_long;
        w_idx_next      = r_idx;
        w_data_next     = r_data;
        w_start_next    = 1'b0;
        w_done_next     = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_rs_next       = rs;
                    w_byte_next     = byte_in;
                    w_nib_only_next = nibble_only;
                    w_bl_next       = backlight;
                    w_long_next     = is_slow_cmd(rs, byte_in, nibble_only);
                    w_idx_next      = 2'd0;
                    w_data_next     = port_byte(byte_in[7:4], 1'b1, backlight, rs);
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i2c_busy) begin
                    w_start_next = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Port byte changes only here, after the writer has finished sampling it.
                if (i2c_done) begin
                    if (r_idx != w_last_idx) begin
                        w_idx_next   = w_idx_inc;
                        w_data_next  = w_following_byte;
                        w_state_next = ST_ISSUE;
                    end else if (w_delay == '0) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_tmr_load   = 1'b1;
                        w_state_next = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign ready     = (r_state == ST_IDLE);
    assign done      = r_done;
    assign i2c_start = r_start;
    assign i2c_addr  = I2C_ADDR;
    assign i2c_data  = r_data;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Scoreboard bench: stimulus queues expected port bytes and delays, a monitor checks them.
module tb_lcd_nibble_sequencer;

    localparam int WR_T    = 6;
    localparam int TIMEOUT = 6000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       nibble_only = 1'b0;
    logic       backlight = 1'b0;
    logic       ready;
    logic       done;
    logic       i2c_start;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data;
    logic       i2c_busy;
    logic       i2c_done = 1'b0;

    logic wr_busy = 1'b0;
    logic hold_busy = 1'b0;
    int   wr_cnt = 0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int total_starts = 0;
    int done_count = 0;

    logic [7:0] exp_data_q[$];
    int         exp_delay_q[$];
    int         exp_nw_q[$];

    lcd_nibble_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rs         (rs),
        .byte_in    (byte_in),
        .nibble_only(nibble_only),
        .backlight  (backlight),
        .ready      (ready),
        .done       (done),
        .i2c_start  (i2c_start),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .i2c_busy   (i2c_busy),
        .i2c_done   (i2c_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign i2c_busy = wr_busy | hold_busy;

    // Writer model: busy for WR_T cycles after a start, then a one-cycle done.
    initial begin
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            if (!rst_n) begin
                wr_busy = 1'b0;
                wr_cnt  = 0;
            end else if (wr_cnt > 0) begin
                wr_cnt = wr_cnt - 1;
                if (wr_cnt == 0) begin
                    i2c_done = 1'b1;
                    wr_busy  = 1'b0;
                end
            end else if (i2c_start) begin
                wr_busy = 1'b1;
                wr_cnt  = WR_T;
            end
        end
    end

    // Monitor
    initial begin
        logic [7:0] exp_b;
        logic [7:0] hold_b;
        logic       prev_start;
        int         last_done_cyc;
        int         writes_seen;
        int         exp_d;
        int         exp_n;
        hold_b = 8'h00;
        prev_start = 1'b0;
        last_done_cyc = 0;
        writes_seen = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_data_q.delete();
                exp_delay_q.delete();
                exp_nw_q.delete();
                writes_seen = 0;
                prev_start = 1'b0;
            end else begin
                if (i2c_start) begin
                    checks++;
                    if (exp_data_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: i2c_data=%02h at cycle %0d, no write expected", i2c_data, cyc);
                    end else begin
                        exp_b = exp_data_q.pop_front();
                        if (i2c_data !== exp_b) begin
                            errors++;
                            $display("FAIL port_byte: got %02h expected %02h", i2c_data, exp_b);
                        end
                    end
                    checks++;
                    if (prev_start !== 1'b0) begin
                        errors++;
                        $display("FAIL start_pulse: i2c_start high for 2 cycles, expected single pulse");
                    end
                    hold_b = i2c_data;
                    writes_seen++;
                    total_starts++;
                    $display("write %0d: i2c_data=%02h cycle=%0d", total_starts, i2c_data, cyc);
                end else if (wr_busy) begin
                    checks++;
                    if (i2c_data !== hold_b) begin
                        errors++;
                        $display("FAIL data_hold: got %02h expected %02h", i2c_data, hold_b);
                    end
                end
                if (i2c_done) last_done_cyc = cyc;
                if (done) begin
                    checks++;
                    if (exp_delay_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done=1 at cycle %0d, none expected", cyc);
                    end else begin
                        exp_d = exp_delay_q.pop_front();
                        exp_n = exp_nw_q.pop_front();
                        if (cyc !== last_done_cyc + exp_d + 1) begin
                            errors++;
                            $display("FAIL done_timing: got cycle %0d expected %0d", cyc, last_done_cyc + exp_d + 1);
                        end
                        checks++;
                        if (writes_seen !== exp_n) begin
                            errors++;
                            $display("FAIL write_count: got %0d expected %0d", writes_seen, exp_n);
                        end
                        checks++;
                        if (ready !== 1'b1) begin
                            errors++;
                            $display("FAIL ready_with_done: got %0b expected 1", ready);
                        end
                        $display("done %0d: cycle=%0d writes=%0d", done_count + 1, cyc, writes_seen);
                    end
                    writes_seen = 0;
                    done_count++;
                end
                prev_start = i2c_start;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp_v);
        end
    endtask

    task automatic send(input logic s_rs, input logic [7:0] s_byte, input logic s_nib,
                        input logic s_bl, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3, input int nw, input int dly);
        int t;
        t = 0;
        while (!ready && t < TIMEOUT) begin
            step();
            t++;
        end
        check_bit("ready_wait", ready, 1'b1);
        if (ready) begin
            rs = s_rs;
            byte_in = s_byte;
            nibble_only = s_nib;
            backlight = s_bl;
            req = 1'b1;
            exp_data_q.push_back(e0);
            exp_data_q.push_back(e1);
            if (nw == 4) begin
                exp_data_q.push_back(e2);
                exp_data_q.push_back(e3);
            end
            exp_delay_q.push_back(dly);
            exp_nw_q.push_back(nw);
            step();
            req = 1'b0;
            check_bit("accept_drops_ready", ready, 1'b0);
        end
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_count < target && t < TIMEOUT) begin
            step();
            t++;
        end
        checks++;
        if (done_count < target) begin
            errors++;
            $display("FAIL done_timeout: done count %0d expected %0d", done_count, target);
        end
    endtask

    initial begin
        int s0;
        int tw;
        rst_n = 1'b0;
        repeat (3) step();
        check_bit("rst_ready", ready, 1'b1);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_start", i2c_start, 1'b0);
        checks++;
        if (i2c_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_data: got %02h expected 00", i2c_data);
        end
        checks++;
        if (i2c_addr !== 7'h27) begin
            errors++;
            $display("FAIL addr: got %02h expected 27", i2c_addr);
        end
        rst_n = 1'b1;
        step();

        send(1'b1, 8'h41, 1'b0, 1'b1, 8'h4D, 8'h49, 8'h1D, 8'h19, 4, 50);
        wait_done(1);

        send(1'b0, 8'h01, 1'b0, 1'b1, 8'h0C, 8'h08, 8'h1C, 8'h18, 4, 2000);
        repeat (3) step();
        rs = 1'b1;
        byte_in = 8'hFF;
        req = 1'b1;
        step();
        req = 1'b0;
        wait_done(2);

        send(1'b0, 8'h30, 1'b1, 1'b0, 8'h34, 8'h30, 8'h00, 8'h00, 2, 50);
        wait_done(3);
        send(1'b1, 8'h7E, 1'b0, 1'b1, 8'h7D, 8'h79, 8'hED, 8'hE9, 4, 50);
        wait_done(4);
        send(1'b1, 8'h02, 1'b0, 1'b1, 8'h0D, 8'h09, 8'h2D, 8'h29, 4, 50);
        wait_done(5);
        send(1'b0, 8'h03, 1'b0, 1'b0, 8'h04, 8'h00, 8'h34, 8'h30, 4, 2000);
        wait_done(6);
        send(1'b0, 8'h01, 1'b1, 1'b1, 8'h0C, 8'h08, 8'h00, 8'h00, 2, 50);
        wait_done(7);

        hold_busy = 1'b1;
        send(1'b0, 8'h28, 1'b0, 1'b1, 8'h2C, 8'h28, 8'h8C, 8'h88, 4, 50);
        s0 = total_starts;
        repeat (5) step();
        checks++;
        if (total_starts !== s0) begin
            errors++;
            $display("FAIL busy_hold: got %0d starts expected %0d", total_starts, s0);
        end
        hold_busy = 1'b0;
        wait_done(8);

        send(1'b1, 8'h41, 1'b0, 1'b1, 8'h4D, 8'h49, 8'h1D, 8'h19, 4, 50);
        tw = 0;
        while (total_starts < s0 + 6 && tw < TIMEOUT) begin
            step();
            tw++;
        end
        step();
        rst_n = 1'b0;
        #1;
        check_bit("abort_ready", ready, 1'b1);
        check_bit("abort_done", done, 1'b0);
        check_bit("abort_start", i2c_start, 1'b0);
        checks++;
        if (i2c_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_data: got %02h expected 00", i2c_data);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        send(1'b1, 8'h41, 1'b0, 1'b1, 8'h4D, 8'h49, 8'h1D, 8'h19, 4, 50);
        wait_done(9);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
